axi_ram_slave: RTL and testbench
================================

AXI_RAM_SLAVE -- requirements
Module: axi_ram_slave

Interface
REQ-001 SHALL have parameter MEM_AW, default 10, meaning word-index width; memory holds 2^MEM_AW 32-bit words.
REQ-002 SHALL have port clk input 1, the single clock; all logic on posedge.
REQ-003 SHALL have port reset input 1, synchronous active-high reset.
REQ-004 SHALL have ports arid input 4 and araddr input 32, the read ID and byte address.
REQ-005 SHALL have ports arlen input 8, arsize input 3 and arburst input 2, the beats-1, size and burst type.
REQ-006 SHALL have ports arlock input 2, arcache input 4 and arprot input 3, all ignored.
REQ-007 SHALL have ports arvalid input 1 and arready output 1, the AR handshake.
REQ-008 SHALL have ports rid output 4, rdata output 32, rresp output 2 and rlast output 1, the read beat payload.
REQ-009 SHALL have ports rvalid output 1 and rready input 1, the R handshake.
REQ-010 SHALL have AW ports awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot, widths and meaning identical to the AR equivalents.
REQ-011 SHALL have ports awvalid input 1 and awready output 1, the AW handshake.
REQ-012 SHALL have ports wid input 4 (ignored), wdata input 32, wstrb input 4, wlast input 1, wvalid input 1 and wready output 1.
REQ-013 SHALL have ports bid output 4, bresp output 2, bvalid output 1 and bready input 1, the write response.

Function
REQ-014 SHALL implement FSM IDLE, RD, WR_DATA, WR_RESP; one transaction outstanding at a time.
REQ-015 In IDLE SHALL drive arready=1 and awready=!arvalid; reads win simultaneous AR/AW; the losing AW stays pending.
REQ-016 On AR handshake SHALL latch id, araddr[MEM_AW+1:2] and arlen; clear beat counter; enter RD next cycle (first rvalid = handshake cycle + 1).
REQ-017 In RD SHALL drive rvalid=1, rdata=mem[cur word], rid=latched id, rlast=(beat==len); rdata held stable while rvalid && !rready.
REQ-018 On each R handshake SHALL increment word index modulo 2^MEM_AW (wrap-around) and beat; on last beat SHALL return to IDLE.
REQ-019 rresp SHALL be 2'b10 (SLVERR) for every beat if arburst!=2'b01 or arsize!=3'b010, else 2'b00; data still returned as INCR/4-byte.
REQ-020 On AW handshake SHALL latch id, address and len, and enter WR_DATA next cycle with wready=1.
REQ-021 On each W handshake SHALL write byte lane i of the current word only where wstrb[i]=1; increment index modulo depth and beat.
REQ-022 The burst SHALL end on beat==len regardless of wlast; bresp=2'b10 if wlast disagreed with beat==len on any beat, or awburst/awsize is illegal, else 2'b00.
REQ-023 After last W handshake (cycle M) SHALL assert bvalid at M+1 with latched bid; hold until bready, then IDLE.
REQ-024 Address bits above MEM_AW+1 and bits [1:0] SHALL be ignored (aliasing).
REQ-025 A write landing mid-read is impossible (FSM exclusive); a read after a write SHALL observe written data.

Reset
REQ-026 While reset=1 all ready/valid outputs SHALL be 0; rid, bid, rresp, bresp and rlast SHALL be 0.
REQ-027 Reset at any point, mid-burst included, SHALL force IDLE next cycle and discard the transaction; memory contents SHALL be retained.
REQ-028 First cycle after reset deasserts SHALL show arready=1.

Configuration
REQ-029 With AXI_RAM_SLAVE_WAIT_EN defined, SHALL insert one idle cycle (rvalid=0 / wready=0) after every R or W handshake, including before bvalid.
REQ-030 Without AXI_RAM_SLAVE_WAIT_EN, beats SHALL stream back-to-back, one per cycle while ready/valid hold.

Verification
REQ-031 AW addr 0x100, len 3, wdata 0xA0..0xA3, wstrb 4'hF -> bvalid 1 cycle after last W, bresp 00; AR 0x100 len 3 -> rdata 0xA0..0xA3, rlast on 4th beat.
REQ-032 Simultaneous arvalid and awvalid in IDLE -> AR accepted, awready=0; AW accepted after read completes.
REQ-033 Write 0x11223344 with wstrb 4'b0101 over 0xFFFFFFFF -> read returns 0xFF22FF44.
REQ-034 AR at last word (MEM_AW=10, addr 0xFFC) len 1 -> beats from words 1023 then 0.
REQ-035 W burst len 3 with wlast on beat 2 -> 4 beats accepted, bresp 2'b10; rready held 0 for 3 cycles -> rdata stable.
REQ-036 Reset asserted on beat 2 of read -> rvalid 0 next cycle, IDLE, earlier memory writes still readable.

Source files
------------

// File: rtl/axi_ram_slave.sv
// AXI3 slave fronting a single-port 32-bit RAM, one burst in flight at a time.
// Optional AXI_RAM_SLAVE_WAIT_EN adds one bubble cycle after every R/W beat.
module axi_ram_slave #(
  parameter int MEM_AW = 10
) (
  input  logic        clk,
  input  logic        reset,

  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,

  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,

  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,

  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,

  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  // state   | meaning
  // IDLE    | waiting for AR (priority) or AW
  // RD      | presenting read beats on R
  // WR_DATA | accepting write beats on W
  // WR_RESP | presenting write response on B
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD      = 2'd1,
    WR_DATA = 2'd2,
    WR_RESP = 2'd3
  } state_t;

  localparam logic [MEM_AW-1:0] IDX_ONE = 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_t state_q, state_d;

  logic [31:0]       mem [0:(1<<MEM_AW)-1];
  logic [3:0]        id_q;
  logic [MEM_AW-1:0] idx_q;
  logic [7:0]        len_q;
  logic [7:0]        beat_q;
  logic              err_q;
  logic              wait_q;

  logic ar_hs, aw_hs, r_hs, w_hs, b_hs;
  logic last_beat;

  assign ar_hs     = arvalid && arready;
  assign aw_hs     = awvalid && awready;
  assign r_hs      = rvalid && rready;
  assign w_hs      = wvalid && wready;
  assign b_hs      = bvalid && bready;
  assign last_beat = (beat_q == len_q);

  // Lock/cache/prot, wid and the aliased address bits carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{arlock, arcache, arprot, awlock, awcache, awprot,
                           wid, araddr, awaddr};

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ar_hs)      state_d = RD;
        else if (aw_hs) state_d = WR_DATA;
      end
      RD:      if (r_hs && last_beat) state_d = IDLE;
      WR_DATA: if (w_hs && last_beat) state_d = WR_RESP;
      WR_RESP: if (b_hs)              state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Everything is forced quiet while reset is high, even before the state register clears.
  always_comb begin
    arready = 1'b0;
    awready = 1'b0;
    rvalid  = 1'b0;
    rid     = 4'd0;
    rdata   = 32'd0;
    rresp   = RESP_OKAY;
    rlast   = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    bid     = 4'd0;
    bresp   = RESP_OKAY;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          arready = 1'b1;
          awready = !arvalid;
        end
        RD: begin
          rvalid = !wait_q;
          rid    = id_q;
          rdata  = mem[idx_q];
          rresp  = err_q ? RESP_SLVERR : RESP_OKAY;
          rlast  = last_beat;
        end
        WR_DATA: wready = !wait_q;
        WR_RESP: begin
          bvalid = !wait_q;
          bid    = id_q;
          bresp  = err_q ? RESP_SLVERR : RESP_OKAY;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      id_q   <= 4'd0;
      idx_q  <= '0;
      len_q  <= 8'd0;
      beat_q <= 8'd0;
      err_q  <= 1'b0;
    end else if (ar_hs) begin
      id_q   <= arid;
      idx_q  <= araddr[MEM_AW+1:2];
      len_q  <= arlen;
      beat_q <= 8'd0;
      err_q  <= (arburst != 2'b01) || (arsize != 3'b010);
    end else if (aw_hs) begin
      id_q   <= awid;
      idx_q  <= awaddr[MEM_AW+1:2];
      len_q  <= awlen;
      beat_q <= 8'd0;
      err_q  <= (awburst != 2'b01) || (awsize != 3'b010);
    end else if (r_hs || w_hs) begin
      idx_q  <= idx_q + IDX_ONE;
      beat_q <= beat_q + 8'd1;
      // The burst length is authoritative; a misplaced wlast only taints the response.
      if (w_hs && (wlast != last_beat)) err_q <= 1'b1;
    end
  end

  // Memory has no reset so contents survive a mid-burst abort.
  always_ff @(posedge clk) begin
    if (w_hs) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[idx_q][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

`ifdef AXI_RAM_SLAVE_WAIT_EN
  // The final R beat returns straight to IDLE, where arready must stay high.
  always_ff @(posedge clk) begin
    if (reset) wait_q <= 1'b0;
    else       wait_q <= (r_hs && !last_beat) || w_hs;
  end
`else
  assign wait_q = 1'b0;
`endif

endmodule

// File: tb/tb_axi_ram_slave.sv
// Scoreboard bench for axi_ram_slave: tasks push expected R/B responses,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_axi_ram_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, arready, awvalid, awready;
  logic        rvalid, rready, rlast;
  logic        wvalid, wready, wlast;
  logic        bvalid, bready;

  axi_ram_slave #(.MEM_AW(10)) dut (
    .clk(clk), .reset(reset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [38:0] exp_r [$];
  logic [5:0]  exp_b [$];
  logic [38:0] r_e;
  logic [5:0]  b_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got no handshake expected one within 100 cycles", name);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (rvalid && rready) begin
        if (exp_r.size() == 0) begin
          tests++; fails++;
          $display("FAIL r_extra: got beat %h expected none", rdata);
        end else begin
          r_e = exp_r.pop_front();
          check("r_beat", {rid, rdata, rresp, rlast}, r_e);
        end
      end
      if (bvalid && bready) begin
        if (exp_b.size() == 0) begin
          tests++; fails++;
          $display("FAIL b_extra: got bresp %0h expected none", bresp);
        end else begin
          b_e = exp_b.pop_front();
          check("b_resp", {bid, bresp}, b_e);
        end
      end
    end
  end

  task automatic push_r(input logic [3:0] id, input logic [31:0] d, input logic [1:0] resp, input logic last);
    exp_r.push_back({id, d, resp, last});
  endtask

  task automatic ar_issue(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size);
    int n;
    arid = id; araddr = addr; arlen = len; arburst = burst; arsize = size; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 100) begin @(negedge clk); n++; end
    if (!arready) timeout("ar_wait");
    @(posedge clk); #1 arvalid = 1'b0;
  endtask

  task automatic aw_issue(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size);
    int n;
    awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = size; awvalid = 1'b1;
    n = 0;
    #1;
    while (!awready && n < 100) begin @(negedge clk); n++; end
    if (!awready) timeout("aw_wait");
    @(posedge clk); #1 awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] base, input logic [7:0] len, input logic [3:0] strb,
                        input int wlast_at);
    int n;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = base + i; wstrb = strb;
      wlast = (wlast_at < 0) ? (i == int'(len)) : (i == wlast_at);
      wvalid = 1'b1;
      n = 0;
      while (!wready && n < 100) begin @(negedge clk); n++; end
      if (!wready) begin
        timeout("w_wait");
        wvalid = 1'b0; wlast = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    check("b_latency", bvalid, 1);
    @(posedge clk); #1;
  endtask

  task automatic r_drain();
    int n;
    n = 0;
    while (!(rvalid && rready && rlast) && n < 100) begin
      if (rvalid && rready) begin @(posedge clk); #1; end
      else @(negedge clk);
      n++;
    end
    if (rvalid && rready && rlast) begin @(posedge clk); #1; end
    else timeout("r_drain");
  endtask

  task automatic wr(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                    input logic [31:0] base, input logic [3:0] strb, input int wlast_at,
                    input logic [1:0] burst, input logic [2:0] size, input logic [1:0] exp_resp);
    exp_b.push_back({id, exp_resp});
    aw_issue(id, addr, len, burst, size);
    w_send(base, len, strb, wlast_at);
  endtask

  task automatic rd(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                    input logic [1:0] burst, input logic [2:0] size,
                    input logic [31:0] base, input logic [1:0] resp);
    for (int i = 0; i <= int'(len); i++) push_r(id, base + i, resp, i == int'(len));
    ar_issue(id, addr, len, burst, size);
    check("r_latency", rvalid, 1);
    r_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200us");
    $fatal(1);
  end

  initial begin
    int cnt;
    reset = 1'b1;
    arid = 0; araddr = 0; arlen = 0; arsize = 3'b010; arburst = 2'b01;
    arlock = 0; arcache = 0; arprot = 0; arvalid = 0;
    awid = 0; awaddr = 0; awlen = 0; awsize = 3'b010; awburst = 2'b01;
    awlock = 0; awcache = 0; awprot = 0; awvalid = 0;
    wid = 0; wdata = 0; wstrb = 0; wlast = 0; wvalid = 0;
    rready = 1'b1; bready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {arready, awready, rvalid, wready, bvalid, rid, bid, rresp, bresp, rlast}, 0);
    reset = 1'b0;
    #1;
    check("post_rst_arready", arready, 1);

    // Basic 4-beat write then read back
    wr(4'd3, 32'h100, 8'd3, 32'hA0, 4'hF, -1, 2'b01, 3'b010, 2'b00);
    rd(4'd5, 32'h100, 8'd3, 2'b01, 3'b010, 32'hA0, 2'b00);

    // Byte strobes
    wr(4'd1, 32'h200, 8'd0, 32'hFFFFFFFF, 4'hF, -1, 2'b01, 3'b010, 2'b00);
    wr(4'd2, 32'h200, 8'd0, 32'h11223344, 4'b0101, -1, 2'b01, 3'b010, 2'b00);
    rd(4'd4, 32'h200, 8'd0, 2'b01, 3'b010, 32'hFF22FF44, 2'b00);

    // Wrap at the top word, and upper-address aliasing
    wr(4'd6, 32'hFFC, 8'd1, 32'h5A5A0000, 4'hF, -1, 2'b01, 3'b010, 2'b00);
    rd(4'd7, 32'hFFC, 8'd1, 2'b01, 3'b010, 32'h5A5A0000, 2'b00);
    rd(4'd8, 32'h1101, 8'd0, 2'b01, 3'b010, 32'hA0, 2'b00);

    // Illegal burst/size -> SLVERR, data still INCR
    rd(4'd9, 32'h100, 8'd1, 2'b10, 3'b010, 32'hA0, 2'b10);
    wr(4'd12, 32'h500, 8'd0, 32'h12345678, 4'hF, -1, 2'b01, 3'b001, 2'b10);

    // Early wlast -> 4 beats, SLVERR; then stalled read
    wr(4'd13, 32'h300, 8'd3, 32'hC0, 4'hF, 2, 2'b01, 3'b010, 2'b10);
    for (int i = 0; i < 4; i++) push_r(4'd14, 32'hC0 + i, 2'b00, i == 3);
    rready = 1'b0;
    ar_issue(4'd14, 32'h300, 8'd3, 2'b01, 3'b010);
    for (int i = 0; i < 3; i++) begin
      check("stall_hold", {rvalid, rdata}, {1'b1, 32'hC0});
      @(posedge clk); #1;
    end
    rready = 1'b1;
    r_drain();

    // Simultaneous AR and AW: read wins, AW waits
    push_r(4'd7, 32'hFF22FF44, 2'b00, 1'b1);
    exp_b.push_back({4'd8, 2'b00});
    arid = 4'd7; araddr = 32'h200; arlen = 0; arburst = 2'b01; arsize = 3'b010;
    awid = 4'd8; awaddr = 32'h400; awlen = 0; awburst = 2'b01; awsize = 3'b010;
    arvalid = 1'b1; awvalid = 1'b1;
    #1;
    check("sim_ready", {arready, awready}, 2'b10);
    @(posedge clk); #1 arvalid = 1'b0;
    check("rd_awready", awready, 0);
    r_drain();
    check("aw_after_read", awready, 1);
    @(posedge clk); #1 awvalid = 1'b0;
    w_send(32'h77, 8'd0, 4'hF, -1);
    rd(4'd9, 32'h400, 8'd0, 2'b01, 3'b010, 32'h77, 2'b00);

    // Reset during beat 2 of a read
    push_r(4'd10, 32'hA0, 2'b00, 1'b0);
    push_r(4'd10, 32'hA1, 2'b00, 1'b0);
    ar_issue(4'd10, 32'h100, 8'd3, 2'b01, 3'b010);
    cnt = 0;
    for (int n = 0; n < 100 && cnt < 2; n++) begin
      if (rvalid && rready) begin cnt++; @(posedge clk); #1; end
      else @(negedge clk);
    end
    if (cnt < 2) timeout("rst_beats");
    reset = 1'b1;
    #1;
    check("rst_mid_outputs", {arready, rvalid, rid, rlast, rresp}, 0);
    @(posedge clk); #1 reset = 1'b0;
    #1;
    check("rst_mid_idle", {arready, rvalid}, 2'b10);
    rd(4'd11, 32'h100, 8'd1, 2'b01, 3'b010, 32'hA0, 2'b00);

    repeat (2) @(posedge clk);
    check("exp_r_left", exp_r.size(), 0);
    check("exp_b_left", exp_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
